// File: rtl/cla_seq_adder_if.sv
// Request/result bundle between a datapath and the sequential CLA adder.
// The sub signal exists only when CLA_SEQ_SUB_EN is defined.
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef CLA_SEQ_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
`ifdef CLA_SEQ_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/cla_seq_adder_ctrl.sv
// Sequences one 4-bit CLA slice over a WIDTH-bit operand, LS nibble first.
// Optional subtract mode (b inverted, carry-in forced to 1) under CLA_SEQ_SUB_EN.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one nibble retired per clock, idx selects the nibble
// DONE  | one-cycle done pulse, result final
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  cla_seq_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / 4;
  localparam int IW     = $clog2(NCHUNK);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cr_q, cr_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [4:0]       slice;
  logic             last;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             accept;

`ifdef CLA_SEQ_SUB_EN
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  assign accept = (state_q == IDLE) && bus.start;
  assign slice  = {1'b0, ra_q[4*idx_q +: 4]} + {1'b0, rb_q[4*idx_q +: 4]} + {4'b0000, cr_q};
  assign last   = (idx_q == IW'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    idx_d  = idx_q;
    cr_d   = cr_q;
    ra_d   = ra_q;
    rb_d   = rb_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (accept) begin
      ra_d   = bus.a;
      rb_d   = b_eff;
      cr_d   = cin_eff;
      idx_d  = '0;
      sum_d  = '0;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (state_q == RUN) begin
      sum_d[4*idx_q +: 4] = slice[3:0];
      cr_d                = slice[4];
      idx_d               = idx_q + IW'(1);
      // Overflow judged on the effective operands, so subtraction uses ~b.
      if (last) begin
        cout_d = slice[4];
        ovf_d  = (ra_q[WIDTH-1] == rb_q[WIDTH-1]) && (slice[3] != ra_q[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cr_q   <= 1'b0;
      ra_q   <= '0;
      rb_q   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cr_q   <= cr_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: doc/cla_seq_adder_ctrl.md
# cla_seq_adder_ctrl

Multi-cycle wide adder controller that sequences a single 4-bit carry-lookahead adder slice over a WIDTH-bit operand, one nibble per clock, least-significant nibble first. Inter-nibble carry is held in a register. Start/busy/done handshake to the requesting datapath. Trades WIDTH/4 cycles of latency for one shared CLA slice in the ALU datapath.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 8; NCHUNK = WIDTH/4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; captured on accepted start
- b  in  WIDTH  operand B; captured on accepted start
- cin  in  1  carry-in to nibble 0; captured on accepted start
- sub  in  1  subtract select; present only with CLA_SEQ_SUB_EN
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result valid
- sum  out  WIDTH  result register
- cout  out  1  carry out of MSB nibble
- ovf  out  1  signed overflow of the full-width result

## Operation
- Internal state: FSM {IDLE, RUN, DONE}, nibble counter idx (width clog2(NCHUNK)), carry register cr, operand registers ra/rb.
- IDLE: on start=1, capture ra=a, rb=b (or ~b, see Configuration), cr=cin (or 1), idx=0, sum=0, cout=0, ovf=0; go to RUN. start=0: stay.
- RUN, each cycle: slice computes ra[4*idx+:4] + rb[4*idx+:4] + cr. Write sum[4*idx+:4], cr <= slice carry-out, idx <= idx+1.
- RUN at idx = NCHUNK-1: also cout <= slice carry-out, ovf <= (ra[MSB] == rb[MSB]) && (slice sum bit 3 != ra[MSB]); go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE unconditionally.
- start while busy (RUN or DONE): ignored, no capture, no effect on the in-flight result; not queued.
- a/b/cin changes after capture: no effect.
- sum, cout, ovf: hold the last result until the next accepted start clears them.
- Arithmetic: unsigned modulo 2^WIDTH. cout is the true carry. ovf uses two's-complement interpretation of the effective operands.

## Timing
- Reset (rst_n=0, asynchronous, any state): state=IDLE, idx=0, cr=0, busy=0, done=0, sum=0, cout=0, ovf=0. Any in-flight operation is abandoned with no done.
- Edge T0 samples start=1 in IDLE. busy=1 from T0 onward.
- Edges T1..TNCHUNK each retire one nibble.
- done=1 in the cycle after edge TNCHUNK. Start-to-done latency is NCHUNK cycles. sum/cout/ovf are final during the done cycle.
- Edge TNCHUNK+1: IDLE, busy=0. The earliest next accepted start is sampled at this edge +1, giving a throughput of one op per NCHUNK+2 cycles.
- Partial sum is visible on sum during RUN. Consumers must qualify with done.

## Configuration
- CLA_SEQ_SUB_EN defined: sub port exists. On accepted start with sub=1, rb=~b and cr=1; cin is ignored and the result is a-b. cout=1 means no borrow. ovf is signed overflow of a-b. With sub=0, behaviour is addition.
- CLA_SEQ_SUB_EN undefined: no sub port, addition only, no inverter logic.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, start 1 cycle: sum=0x5555, cout=0, ovf=0, done high exactly 4 cycles after the start edge, for 1 cycle.
- a=0xFFFF, b=0x0001, cin=0: sum=0x0000, cout=1, ovf=0. Carry ripples through all 4 nibbles. Also a=0xFFFF, b=0x0000, cin=1 gives the same result.
- a=0x7FFF, b=0x0001: sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x8000: sum=0x0000, cout=1, ovf=1.
- Start 0x0001+0x0001, then start=1 with a=0xAAAA on every busy cycle: the first done reports 0x0002. The next op is accepted only after busy falls.
- rst_n=0 asynchronously during the 2nd RUN cycle: all outputs 0 immediately, no done. After release, start 0x0F0F+0x00F1 gives 0x1000 after 4 cycles.
- CLA_SEQ_SUB_EN, sub=1: 0x0005-0x0007 gives 0xFFFE, cout=0, ovf=0. 0x8000-0x0001 gives 0x7FFF, cout=1, ovf=1.
